vram_blit_engine: RTL and testbench
===================================

VRAM_BLIT_ENGINE -- requirements
Module: vram_blit_engine

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 15, VRAM address width; DATA_W, default 8, VRAM data width; MEM_DEPTH, default 24576, number of valid VRAM bytes.
REQ-002 user_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 cmd_valid in 1 / cmd_ready out 1: command handshake; accepted on a cycle where both are high.
REQ-005 cmd_op  in  1  operation: 0 = fill, 1 = copy.
REQ-006 cmd_dst, cmd_src, cmd_len  in  ADDR_W each  destination start, source start (copy only), byte count.
REQ-007 cmd_fill  in  DATA_W  fill byte.
REQ-008 busy out 1 high while a command executes; done out 1 one-cycle completion pulse; err out 1 one-cycle range-error pulse.
REQ-009 host_req, host_we in 1; host_addr in ADDR_W; host_wdata in DATA_W: single-byte host access request.
REQ-010 host_gnt out 1 access performed this cycle; host_rvalid out 1; host_rdata out DATA_W: read result.
REQ-011 vram_addr out ADDR_W, vram_wdata out DATA_W, vram_we out 1, vram_rdata in DATA_W: the VRAM user port; vram_rdata is registered inside the memory and returns the byte addressed one cycle earlier.

Function
REQ-012 The FSM SHALL have the states IDLE, FILL, CRD (copy read), CWR (copy write) and DONE.
REQ-013 cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in FILL, CRD and CWR.
REQ-014 On acceptance, the block SHALL latch dst, src, len, fill and op, and clear the byte counter.
- len = 0: go to DONE.
- Range error (dst+len > MEM_DEPTH, or for copy also src+len > MEM_DEPTH; sums computed ADDR_W+1 bits wide): pulse err, go to IDLE next cycle, perform no VRAM writes, do not pulse done.
- Otherwise: go to FILL (op 0) or CRD (op 1).
REQ-015 In FILL, each non-stalled cycle SHALL drive vram_we=1, vram_addr=dst+k, vram_wdata=fill, then increment k; after the write with k=len-1, go to DONE.
REQ-016 Copy SHALL proceed in ascending address order, one byte per CRD/CWR pair.
- CRD drives vram_addr=src+k with vram_we=0.
- CWR drives vram_addr=dst+k, vram_wdata=vram_rdata, vram_we=1, then increments k.
- CWR returns to CRD, or goes to DONE after k=len-1.
- Overlapping ranges with dst>src SHALL replicate the source pattern; this is defined behaviour.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-018 vram_* outputs SHALL be combinational from the current state, the latched registers and the host inputs, with no added latency.
REQ-019 Without host contention, for a command accepted in cycle t:
- fill of N bytes: writes in t+1..t+N, done at t+N+1;
- copy of N bytes: last write at t+2N, done at t+2N+1.
REQ-020 Host arbitration:
- A host_req in IDLE, DONE, FILL or CRD SHALL be granted (host_gnt=1) that cycle.
- The VRAM port carries host_addr/host_wdata/host_we that cycle.
- The engine stalls that cycle: no state or counter change.
REQ-021 host_req in CWR SHALL NOT be granted; host_gnt=0 and the host holds its request, which is granted the next cycle.
REQ-022 host_gnt SHALL be combinational; host_rvalid SHALL be 1 in the cycle after a granted read (host_we=0), with host_rdata=vram_rdata.
REQ-023 A cmd_valid arriving during execution SHALL be ignored until cmd_ready=1; commands are never queued.
REQ-024 Addresses SHALL never wrap: a command that is not rejected never accesses addresses at or above MEM_DEPTH.

Reset
REQ-025 rst SHALL force IDLE and clear k and all latched registers.
- Outputs during the reset cycle and after it: busy=0, done=0, err=0, host_rvalid=0, host_gnt=0.
- From the cycle after rst deasserts: cmd_ready=1, vram_we=0.
REQ-026 rst asserted mid-command SHALL abort the command with no further VRAM writes and no done pulse; bytes already written stay written.
REQ-027 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-028 Fill dst=0x0100, len=4, fill=0xA5, no host -> writes to 0x0100..0x0103 on cycles t+1..t+4, done at t+5, busy high t+1..t+4.
REQ-029 Copy src=0x0000 (bytes 11,22,33), dst=0x5000, len=3 -> 0x5000..0x5002 = 11,22,33; done at t+7.
REQ-030 Fill len=8 with a host read of 0x0200 held from t+3 -> host_gnt at t+3, host_rvalid at t+4, done delayed one cycle to t+10.
REQ-031 Copy with host_req raised during CWR -> no grant in CWR, grant in the following CRD, copied data correct.
REQ-032 Fill dst=0x5FFF, len=2 -> err pulse at t+1, no VRAM writes, no done, cmd_ready=1 at t+2; len=0 -> done at t+2, no writes.
REQ-033 Fill len=100 with rst pulsed at t+10 -> exactly 9 bytes written, IDLE and cmd_ready=1 after reset, no done pulse.

Source files
------------

// File: rtl/vram_blit_engine.sv
// rtl/vram_blit_engine.sv - VRAM fill/copy blit engine with single-byte host access arbitration
module vram_blit_engine #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 24576
) (
    input  logic              user_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CRD,
        S_CWR,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE_L   = ADDR_W'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] k_q;
    logic [DATA_W-1:0] fill_q;
    logic              op_q;
    logic              done_q;
    logic              err_q;
    logic              rvalid_q;

    logic [ADDR_W:0]   dst_end_d;
    logic [ADDR_W:0]   src_end_d;
    logic              range_err_d;
    logic              last_d;
    logic              gnt_d;

    // Range check on the raw command so the first write can land in the cycle after acceptance
    always_comb begin
        dst_end_d   = {1'b0, cmd_dst} + {1'b0, cmd_len};
        src_end_d   = {1'b0, cmd_src} + {1'b0, cmd_len};
        range_err_d = (dst_end_d > DEPTH_L) || (cmd_op && (src_end_d > DEPTH_L));
        last_d      = (k_q == (len_q - ONE_L));
    end

    // Host wins the port in every state except CWR, where the copy byte is already in flight
    always_comb begin
        gnt_d = host_req && !rst && (state_q != S_CWR);
    end

    // Status outputs; reset masks the registered pulses in the reset cycle itself
    always_comb begin
        host_gnt    = gnt_d;
        cmd_ready   = !rst && (state_q == S_IDLE);
        busy        = !rst && ((state_q == S_FILL) || (state_q == S_CRD) || (state_q == S_CWR));
        done        = !rst && done_q;
        err         = !rst && err_q;
        host_rvalid = !rst && rvalid_q;
        host_rdata  = vram_rdata;
    end

    // VRAM port mux: host access first, otherwise the engine's current fill/copy beat
    always_comb begin
        vram_addr  = '0;
        vram_wdata = '0;
        vram_we    = 1'b0;
        if (gnt_d) begin
            vram_addr  = host_addr;
            vram_wdata = host_wdata;
            vram_we    = host_we;
        end else begin
            case (state_q)
                S_FILL: begin
                    vram_addr  = dst_q + k_q;
                    vram_wdata = fill_q;
                    vram_we    = (len_q != '0);
                end
                S_CRD: begin
                    vram_addr  = src_q + k_q;
                end
                S_CWR: begin
                    vram_addr  = dst_q + k_q;
                    vram_wdata = vram_rdata;
                    vram_we    = 1'b1;
                end
                default: begin
                    vram_addr  = '0;
                end
            endcase
        end
        if (rst) begin
            vram_we = 1'b0;
        end
    end

    // Engine FSM; a granted host access freezes FILL/CRD for that cycle
    always_ff @(posedge user_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dst_q    <= '0;
            src_q    <= '0;
            len_q    <= '0;
            k_q      <= '0;
            fill_q   <= '0;
            op_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= gnt_d && !host_we;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dst_q  <= cmd_dst;
                        src_q  <= cmd_src;
                        len_q  <= cmd_len;
                        fill_q <= cmd_fill;
                        op_q   <= cmd_op;
                        k_q    <= '0;
                        if (range_err_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (cmd_op && (cmd_len != '0)) begin
                            state_q <= S_CRD;
                        end else begin
                            // Zero-length commands of either kind pass one write-free FILL beat
                            state_q <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (!gnt_d) begin
                        k_q <= k_q + ONE_L;
                        if ((len_q == '0) || last_d) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_CRD: begin
                    if (!gnt_d) begin
                        state_q <= S_CWR;
                    end
                end
                S_CWR: begin
                    k_q <= k_q + ONE_L;
                    if (last_d) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_CRD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_blit_engine.sv
// tb/tb_vram_blit_engine.sv - directed self-checking bench for vram_blit_engine
module tb_vram_blit_engine;

    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int DEPTH = 24576;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_src;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] cmd_fill;
    logic          busy;
    logic          done;
    logic          err;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_wdata;
    logic          vram_we;
    logic [DW-1:0] vram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int w0;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_q = '0;
    logic [DW-1:0] cp [0:2];

    always #5 clk = ~clk;

    // Memory model with one-cycle registered read and a write counter
    always @(posedge clk) begin
        if (vram_we && (int'(vram_addr) < DEPTH)) mem[vram_addr] <= vram_wdata;
        if (vram_we) wr_cnt <= wr_cnt + 1;
        rdata_q <= (int'(vram_addr) < DEPTH) ? mem[vram_addr] : '0;
    end
    assign vram_rdata = rdata_q;

    vram_blit_engine #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .user_clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .busy(busy), .done(done), .err(err),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                         input logic [AW-1:0] len, input logic [DW-1:0] fill);
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_len = len; cmd_fill = fill;
        cmd_valid = 1'b1;
        #1;
        chk("accept_ready", cmd_ready, 1);
        nxt();
        cmd_valid = 1'b0;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        chk("hwr_gnt", host_gnt, 1);
        nxt();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        #1;
        chk("hrd_gnt", host_gnt, 1);
        nxt();
        host_req = 1'b0;
        #1;
        chk("hrd_rvalid", host_rvalid, 1);
        chk(tag, host_rdata, exp);
        nxt();
    endtask

    initial begin
        cp[0] = 8'h11; cp[1] = 8'h22; cp[2] = 8'h33;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_dst = '0; cmd_src = '0; cmd_len = '0;
        cmd_fill = '0; host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        // reset cycle: all status low, host not granted
        nxt();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_gnt", host_gnt, 0);
        nxt();
        rst = 1'b0; host_req = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_we", vram_we, 0);
        nxt();

        // fill 0x0100, len 4, 0xA5
        issue(1'b0, 15'h0100, 15'h0000, 15'd4, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_we", vram_we, 1);
            chk("fill_addr", vram_addr, 32'h100 + i);
            chk("fill_wdata", vram_wdata, 8'hA5);
            chk("fill_busy", busy, 1);
            chk("fill_done_early", done, 0);
            nxt();
        end
        #1;
        chk("fill_done", done, 1);
        chk("fill_done_busy", busy, 0);
        chk("fill_done_we", vram_we, 0);
        chk("fill_done_ready", cmd_ready, 0);
        nxt();
        #1;
        chk("fill_idle_ready", cmd_ready, 1);
        chk("fill_done_once", done, 0);
        nxt();

        host_wr(15'h0000, 8'h11);
        host_wr(15'h0001, 8'h22);
        host_wr(15'h0002, 8'h33);
        host_wr(15'h0200, 8'h77);
        host_rd("fill_mem_0103", 15'h0103, 8'hA5);

        // copy 0x0000 -> 0x5000, len 3
        issue(1'b1, 15'h5000, 15'h0000, 15'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("crd_we", vram_we, 0);
            chk("crd_addr", vram_addr, i);
            chk("crd_busy", busy, 1);
            nxt();
            #1;
            chk("cwr_we", vram_we, 1);
            chk("cwr_addr", vram_addr, 32'h5000 + i);
            chk("cwr_wdata", vram_wdata, cp[i]);
            chk("cwr_done_early", done, 0);
            nxt();
        end
        #1;
        chk("copy_done", done, 1);
        nxt();
        host_rd("copy_mem_5002", 15'h5002, 8'h33);

        // fill len 8 with a host read stalling the engine at t+3
        issue(1'b0, 15'h0300, 15'h0000, 15'd8, 8'h5A);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_fill_addr", vram_addr, 32'h300 + i);
            nxt();
        end
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0200;
        #1;
        chk("stall_gnt", host_gnt, 1);
        chk("stall_vaddr", vram_addr, 32'h200);
        chk("stall_we", vram_we, 0);
        chk("stall_busy", busy, 1);
        nxt();
        host_req = 1'b0;
        #1;
        chk("stall_rvalid", host_rvalid, 1);
        chk("stall_rdata", host_rdata, 8'h77);
        chk("stall_resume_we", vram_we, 1);
        chk("stall_resume_addr", vram_addr, 32'h302);
        nxt();
        for (int i = 3; i < 8; i++) begin
            #1;
            chk("stall_fill_addr", vram_addr, 32'h300 + i);
            chk("stall_done_early", done, 0);
            nxt();
        end
        #1;
        chk("stall_done", done, 1);
        nxt();

        // copy with host request raised in CWR
        issue(1'b1, 15'h5100, 15'h0000, 15'd2, 8'h00);
        #1;
        chk("hc_crd0_addr", vram_addr, 0);
        nxt();
        host_req = 1'b1; host_we = 1'b0; host_addr = 15'h0002;
        #1;
        chk("hc_cwr_no_gnt", host_gnt, 0);
        chk("hc_cwr_we", vram_we, 1);
        chk("hc_cwr_addr", vram_addr, 32'h5100);
        chk("hc_cwr_wdata", vram_wdata, 8'h11);
        nxt();
        #1;
        chk("hc_crd_gnt", host_gnt, 1);
        chk("hc_crd_vaddr", vram_addr, 2);
        chk("hc_crd_we", vram_we, 0);
        nxt();
        host_req = 1'b0;
        #1;
        chk("hc_rvalid", host_rvalid, 1);
        chk("hc_rdata", host_rdata, 8'h33);
        chk("hc_crd1_addr", vram_addr, 1);
        chk("hc_crd1_we", vram_we, 0);
        nxt();
        #1;
        chk("hc_cwr1_addr", vram_addr, 32'h5101);
        chk("hc_cwr1_wdata", vram_wdata, 8'h22);
        nxt();
        #1;
        chk("hc_done", done, 1);
        nxt();
        host_rd("hc_mem_5100", 15'h5100, 8'h11);
        host_rd("hc_mem_5101", 15'h5101, 8'h22);

        // range errors, zero length, exact upper boundary
        w0 = wr_cnt;
        issue(1'b0, 15'h5FFF, 15'h0000, 15'd2, 8'hEE);
        #1;
        chk("rerr_err", err, 1);
        chk("rerr_done", done, 0);
        chk("rerr_we", vram_we, 0);
        chk("rerr_ready", cmd_ready, 0);
        chk("rerr_busy", busy, 0);
        nxt();
        #1;
        chk("rerr_ready_back", cmd_ready, 1);
        chk("rerr_err_once", err, 0);
        nxt();
        issue(1'b1, 15'h0000, 15'h5FFF, 15'd2, 8'h00);
        #1;
        chk("rerr_src_err", err, 1);
        chk("rerr_src_we", vram_we, 0);
        nxt();
        #1;
        chk("rerr_src_ready", cmd_ready, 1);
        nxt();
        issue(1'b0, 15'h0010, 15'h0000, 15'd0, 8'h44);
        #1;
        chk("len0_done_early", done, 0);
        chk("len0_we", vram_we, 0);
        nxt();
        #1;
        chk("len0_done", done, 1);
        chk("len0_we2", vram_we, 0);
        nxt();
        chk("rerr_no_writes", wr_cnt - w0, 0);
        issue(1'b0, 15'h5FFE, 15'h0000, 15'd2, 8'hC3);
        #1;
        chk("edge_err", err, 0);
        chk("edge_addr0", vram_addr, 32'h5FFE);
        nxt();
        #1;
        chk("edge_addr1", vram_addr, 32'h5FFF);
        chk("edge_we1", vram_we, 1);
        nxt();
        #1;
        chk("edge_done", done, 1);
        nxt();
        host_rd("edge_mem_5fff", 15'h5FFF, 8'hC3);

        // reset mid-fill
        w0 = wr_cnt;
        issue(1'b0, 15'h1000, 15'h0000, 15'd100, 8'h99);
        repeat (9) nxt();
        rst = 1'b1;
        #1;
        chk("abort_rst_we", vram_we, 0);
        chk("abort_rst_busy", busy, 0);
        chk("abort_rst_done", done, 0);
        nxt();
        rst = 1'b0;
        #1;
        chk("abort_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_wr_count", wr_cnt - w0, 9);
        nxt();
        repeat (3) begin
            #1;
            chk("abort_no_done", done, 0);
            chk("abort_no_we", vram_we, 0);
            nxt();
        end
        host_rd("abort_mem_1008", 15'h1008, 8'h99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
